// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and widths for the stage-2 prep path.
package rsp_s2_prep_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned FLUSH_CNT_W = 8;
  localparam int unsigned SMP_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/rsp_s2_prep_frame_ctrl_if.sv
// Framed sample stream into and out of the stage-2 prep frame controller.
interface rsp_s2_prep_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_sof;
  logic                  i_eof;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sof;
  logic                  o_eof;
  logic                  o_flush;

  modport slave (
    input  i_valid, i_data, i_sof, i_eof,
    output o_ready, o_valid, o_data, o_sof, o_eof, o_flush
  );

  modport master (
    output i_valid, i_data, i_sof, i_eof,
    input  o_ready, o_valid, o_data, o_sof, o_eof, o_flush
  );

endinterface

// File: rtl/rsp_s2_prep_frame_ctrl.sv
// Registers framed samples onto the output stream, appends FLUSH_LEN zero
// samples after each frame and flags framing errors.
module rsp_s2_prep_frame_ctrl
  import rsp_s2_prep_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int FLUSH_LEN     = 2,
  parameter int MAX_FRAME_LEN = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rsp_s2_prep_frame_ctrl_if.slave strm,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic                   o_err
);

  localparam logic [SMP_CNT_W-1:0]   MAX_CNT    = SMP_CNT_W'(MAX_FRAME_LEN);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);

  state_t                 state, state_n;
  logic [SMP_CNT_W-1:0]   smp_cnt, smp_cnt_n, smp_inc;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_n;
  logic                   cnt_inc_q, cnt_inc_n;
  logic                   valid_n, sof_n, eof_n, flush_n, err_n;
  logic [DATA_WIDTH-1:0]  data_n;
  logic                   accept;

  assign strm.o_ready = (state != ST_FLUSH);
  assign accept       = strm.i_valid & strm.o_ready;
  assign smp_inc      = smp_cnt + 1'b1;

  always_comb begin
    state_n     = state;
    smp_cnt_n   = smp_cnt;
    flush_cnt_n = flush_cnt;
    cnt_inc_n   = 1'b0;
    valid_n     = 1'b0;
    data_n      = '0;
    sof_n       = 1'b0;
    eof_n       = 1'b0;
    flush_n     = 1'b0;
    err_n       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        flush_cnt_n = '0;
        smp_cnt_n   = '0;
        if (accept) begin
          if (strm.i_sof) begin
            valid_n   = 1'b1;
            data_n    = strm.i_data;
            sof_n     = 1'b1;
            smp_cnt_n = SMP_CNT_W'(1);
            if (strm.i_eof) begin
              eof_n   = 1'b1;
              state_n = ST_FLUSH;
            end else begin
              state_n = ST_RUN;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (strm.i_sof) begin
            // overlapping SOF: drop it and close the open frame without EOF
            err_n   = 1'b1;
            state_n = ST_FLUSH;
          end else begin
            valid_n   = 1'b1;
            data_n    = strm.i_data;
            smp_cnt_n = smp_inc;
            if (strm.i_eof || smp_inc == MAX_CNT) begin
              eof_n   = 1'b1;
              err_n   = ~strm.i_eof;
              state_n = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        valid_n     = 1'b1;
        flush_n     = 1'b1;
        flush_cnt_n = flush_cnt + 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          flush_cnt_n = '0;
          cnt_inc_n   = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      smp_cnt   <= '0;
      flush_cnt <= '0;
      cnt_inc_q <= 1'b0;
    end else begin
      state     <= state_n;
      smp_cnt   <= smp_cnt_n;
      flush_cnt <= flush_cnt_n;
      cnt_inc_q <= cnt_inc_n;
    end
  end

  // frame count lands one cycle after the last flush sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strm.o_valid <= 1'b0;
      strm.o_data  <= '0;
      strm.o_sof   <= 1'b0;
      strm.o_eof   <= 1'b0;
      strm.o_flush <= 1'b0;
      o_err        <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      strm.o_valid <= valid_n;
      strm.o_data  <= data_n;
      strm.o_sof   <= sof_n;
      strm.o_eof   <= eof_n;
      strm.o_flush <= flush_n;
      o_err        <= err_n;
      if (cnt_inc_q) begin
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/rsp_s2_prep_frame_ctrl.md
# rsp_s2_prep_frame_ctrl

Frame controller directly upstream of the stage-2 prep delay line (`rsp_s2_prep_delay_data`). It accepts a framed, valid-qualified sample stream and registers each frame onto a per-cycle stream. After each frame it appends FLUSH_LEN zero samples so the delay line and the following filter drain cleanly before the next frame. It also polices framing: stray samples, overlapping SOF and over-length frames.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement, passed through unchanged).
- FLUSH_LEN, 2, zero samples appended after every frame; set equal to downstream delay DEPTH; range 1..255.
- MAX_FRAME_LEN, 4096, maximum samples per frame including SOF/EOF samples; range 2..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input sample qualifier.
- i_data  in  DATA_WIDTH  input sample.
- i_sof  in  1  first sample of frame; meaningful only with i_valid.
- i_eof  in  1  last sample of frame; meaningful only with i_valid.
- o_ready  out  1  high when input is accepted; low in FLUSH.
- o_valid  out  1  output sample qualifier.
- o_data  out  DATA_WIDTH  output sample (zero on flush samples).
- o_sof  out  1  marks first frame sample.
- o_eof  out  1  marks last real frame sample.
- o_flush  out  1  marks an appended zero sample.
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.
- o_err  out  1  one-cycle pulse on a framing error.

## Operation
- FSM states: IDLE, RUN, FLUSH. Reset state is IDLE.
- o_ready is combinational from the state only: it is 0 in FLUSH and 1 otherwise.
- Accept means i_valid & o_ready.

IDLE:
- Accept with i_sof=1: forward the sample with o_sof=1 and set the sample counter to 1.
  - If i_eof=1 on the same sample, also assert o_eof and go to FLUSH (single-sample frame).
  - Otherwise go to RUN.
- Accept with i_sof=0: drop the sample and pulse o_err.

RUN:
- Accept with i_sof=0: forward the sample and increment the sample counter.
  - i_eof=1: assert o_eof and go to FLUSH.
  - Counter reaches MAX_FRAME_LEN without i_eof: force o_eof on that sample, pulse o_err, go to FLUSH.
- Accept with i_sof=1 (overlapping frame): drop the sample, pulse o_err, go to FLUSH. The previous frame closes without an o_eof.
- No accept: o_valid=0. Gaps inside a frame are allowed.

FLUSH:
- Emit FLUSH_LEN consecutive samples: o_valid=1, o_data=0, o_flush=1.
- i_valid is ignored; upstream must hold off while o_ready=0.
- After the last flush sample: increment o_frame_cnt and return to IDLE. Aborted frames are counted as well.

Other rules:
- o_sof, o_eof and o_flush are never asserted while o_valid=0.
- o_sof/o_eof are never asserted together with o_flush.
- The flush counter is 8 bits and the sample counter is 16 bits; both are cleared on entry to the next frame.

## Timing
- Latency input to output is 1 cycle; all outputs are registered except o_ready.
- Reset values: o_valid, o_data, o_sof, o_eof, o_flush, o_err and o_frame_cnt are all 0; o_ready is 1 (IDLE).
- The last real sample (o_eof) at cycle n is followed by flush samples at n+1 .. n+FLUSH_LEN.
- o_ready drops in the cycle after the EOF sample is accepted and rises again in the cycle the FSM re-enters IDLE. A new SOF is accepted FLUSH_LEN+1 cycles after the EOF accept at the earliest.
- o_frame_cnt updates in the cycle after the last flush sample.
- o_err is a single-cycle pulse, one cycle after the offending input.
- Reset mid-frame or mid-flush clears all state immediately. No partial flush is emitted afterwards.

## Structure
- A shared package `rsp_s2_prep_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH);
  - the frame-counter width constant (16);
  - the flush-counter width constant (8).
- No sub-module is needed. The top-level stage 2 prep wrapper instantiates this block followed by `rsp_s2_prep_delay_data`, with DEPTH equal to FLUSH_LEN.

## Test plan
- **Normal frame** (FLUSH_LEN=2): 4 back-to-back samples 0x0001..0x0004 with SOF on the first and EOF on the last.
  - Output: the same 4 samples 1 cycle later, o_sof on 0x0001, o_eof on 0x0004.
  - Then two samples of 0x0000 with o_flush=1; o_ready low for 2 cycles; o_frame_cnt=1.
- **Single-sample frame**: SOF and EOF on sample 0x7FFF.
  - Output: one sample with both o_sof and o_eof, then 2 flush samples; o_frame_cnt increments.
- **Stray sample**: in IDLE, i_valid with i_sof=0 and data 0x1234.
  - No o_valid; o_err pulses for 1 cycle; state stays IDLE.
- **Overlapping SOF**: SOF, 2 samples, then a second SOF in RUN.
  - The second SOF sample is dropped, o_err pulses, flush follows, and no o_eof is emitted.
- **Over-length frame** (MAX_FRAME_LEN=8): SOF followed by 10 samples with no EOF.
  - o_eof is forced on the 8th sample with an o_err pulse; samples 9 and 10, presented during FLUSH, are not accepted.
- **Reset mid-flush**: assert rst_n=0 during the first flush sample.
  - All outputs go to 0 and o_ready to 1 asynchronously; a frame after reset behaves as in the normal-frame case.
